// File: rtl/codec_cfg_sequencer.sv
// WM8731 boot-table and runtime register-write sequencer feeding the shared I2C byte master.
// Optional macro CODEC_CFG_RETRY_EN: NACKed commands are retried up to MAX_RETRY extra times.
module codec_cfg_sequencer #(
   parameter logic [7:0]  DEV_ADDR   = 8'h34,
   parameter int unsigned GAP_CYCLES = 64,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        req_valid,
   input  logic [6:0]  req_addr,
   input  logic [8:0]  req_data,
   output logic        req_ready,
   output logic        cmd_valid,
   output logic [23:0] cmd_word,
   input  logic        cmd_ready,
   input  logic        done,
   input  logic        ack_ok,
   output logic        busy,
   output logic        init_done,
   output logic        error,
   output logic [2:0]  dbg_state
);

   // Valid/ready: a transfer happens on a posedge where valid and ready are both high;
   // once valid rises it stays high with its payload unchanged until that edge.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_GAP   = 3'd3,
      S_READY = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam int unsigned    GAP_W    = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);
   localparam logic [3:0]     LAST_IDX = 4'd8;

   if (GAP_CYCLES < 1) begin : g_gap_check
      $error("GAP_CYCLES must be at least 1");
   end
   if (MAX_RETRY > 255) begin : g_retry_check
      $error("MAX_RETRY must fit in 8 bits");
   end

   // Boot table entries as {reg_addr[6:0], data[8:0]}; index 8 activates the codec.
   function automatic logic [15:0] boot_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    boot_entry = {7'd15, 9'h000};
         4'd1:    boot_entry = {7'd4,  9'h014};
         4'd2:    boot_entry = {7'd2,  9'h079};
         4'd3:    boot_entry = {7'd3,  9'h079};
         4'd4:    boot_entry = {7'd7,  9'h052};
         4'd5:    boot_entry = {7'd8,  9'h000};
         4'd6:    boot_entry = {7'd5,  9'h011};
         4'd7:    boot_entry = {7'd6,  9'h000};
         4'd8:    boot_entry = {7'd9,  9'h001};
         default: boot_entry = 16'h0000;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             boot_q, boot_d;
   logic             gap_to_ready_q, gap_to_ready_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [23:0]      cmd_word_q, cmd_word_d;
   logic             busy_q, busy_d;
   logic             init_done_q, init_done_d;
   logic             error_q, error_d;
   logic             ready_q, ready_d;
   logic             restart;

`ifdef CODEC_CFG_RETRY_EN
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RETRY_W-1:0] retry_q, retry_d;
`endif

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      gap_cnt_d      = gap_cnt_q;
      boot_d         = boot_q;
      gap_to_ready_d = gap_to_ready_q;
      cmd_word_d     = cmd_word_q;
      init_done_d    = init_done_q;
      restart        = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
      retry_d        = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) restart = 1'b1;
         end
         S_ISSUE: begin
            if (cmd_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done) begin
               gap_cnt_d = '0;
               if (ack_ok) begin
                  state_d = S_GAP;
`ifdef CODEC_CFG_RETRY_EN
                  retry_d = '0;
`endif
                  if (boot_q && (idx_q != LAST_IDX)) begin
                     idx_d          = idx_q + 4'd1;
                     gap_to_ready_d = 1'b0;
                  end else begin
                     gap_to_ready_d = 1'b1;
                  end
               end else begin
`ifdef CODEC_CFG_RETRY_EN
                  if (retry_q < RETRY_W'(MAX_RETRY)) begin
                     retry_d        = retry_q + RETRY_W'(1);
                     state_d        = S_GAP;
                     gap_to_ready_d = 1'b0;
                  end else begin
                     state_d = S_ERR;
                  end
`else
                  state_d = S_ERR;
`endif
               end
            end
         end
         S_GAP: begin
            // Exiting on GAP_LAST keeps the state here GAP_CYCLES+1 cycles after done.
            if (gap_cnt_q == GAP_LAST) begin
               if (gap_to_ready_q) begin
                  state_d     = S_READY;
                  boot_d      = 1'b0;
                  init_done_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  if (boot_q) cmd_word_d = {DEV_ADDR, boot_entry(idx_q)};
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         S_READY: begin
            if (start) begin
               restart = 1'b1;
            end else if (req_valid) begin
               state_d    = S_ISSUE;
               boot_d     = 1'b0;
               cmd_word_d = {DEV_ADDR, req_addr, req_data};
            end
         end
         S_ERR: begin
            if (start) restart = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (restart) begin
         state_d     = S_ISSUE;
         idx_d       = 4'd0;
         boot_d      = 1'b1;
         cmd_word_d  = {DEV_ADDR, boot_entry(4'd0)};
         init_done_d = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
         retry_d     = '0;
`endif
      end

      cmd_valid_d = (state_d == S_ISSUE);
      busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_GAP);
      error_d     = (state_d == S_ERR);
      ready_d     = (state_d == S_READY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         idx_q          <= 4'd0;
         gap_cnt_q      <= '0;
         boot_q         <= 1'b0;
         gap_to_ready_q <= 1'b0;
         cmd_valid_q    <= 1'b0;
         cmd_word_q     <= 24'h000000;
         busy_q         <= 1'b0;
         init_done_q    <= 1'b0;
         error_q        <= 1'b0;
         ready_q        <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
         retry_q        <= '0;
`endif
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         gap_cnt_q      <= gap_cnt_d;
         boot_q         <= boot_d;
         gap_to_ready_q <= gap_to_ready_d;
         cmd_valid_q    <= cmd_valid_d;
         cmd_word_q     <= cmd_word_d;
         busy_q         <= busy_d;
         init_done_q    <= init_done_d;
         error_q        <= error_d;
         ready_q        <= ready_d;
`ifdef CODEC_CFG_RETRY_EN
         retry_q        <= retry_d;
`endif
      end
   end

   // A start in READY takes priority, so the request must not see ready that cycle.
   assign req_ready = ready_q && !start;
   assign cmd_valid = cmd_valid_q;
   assign cmd_word  = cmd_word_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;
   assign error     = error_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a simple I2C-master model driven from tasks.
module tb_codec_cfg_sequencer;

   localparam int GAP = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        req_valid = 1'b0;
   logic [6:0]  req_addr = 7'd0;
   logic [8:0]  req_data = 9'd0;
   logic        req_ready;
   logic        cmd_valid;
   logic [23:0] cmd_word;
   logic        cmd_ready = 1'b0;
   logic        done = 1'b0;
   logic        ack_ok = 1'b0;
   logic        busy;
   logic        init_done;
   logic        error;
   logic [2:0]  dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [23:0] exp_q[$];
   logic [23:0] boot_words [9] = '{24'h341E00, 24'h340814, 24'h340479, 24'h340679, 24'h340E52,
                                   24'h341000, 24'h340A11, 24'h340C00, 24'h341201};

   codec_cfg_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cmd_valid (cmd_valid),
      .cmd_word  (cmd_word),
      .cmd_ready (cmd_ready),
      .done      (done),
      .ack_ok    (ack_ok),
      .busy      (busy),
      .init_done (init_done),
      .error     (error),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for cmd_valid; gap counts negedges since the call (the negedge after the last done).
   task automatic wait_cmd(input bit spurious, output logic [23:0] word, output int gap);
      int n = 0;
      while (cmd_valid !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
         done   = spurious && (n == 10);
         ack_ok = spurious && (n == 10);
      end
      done   = 1'b0;
      ack_ok = 1'b0;
      gap    = n;
      word   = cmd_word;
      if (cmd_valid !== 1'b1) check_eq("cmd_valid_timeout", cmd_valid, 1);
   endtask

   task automatic accept_cmd(input int stall, input logic [23:0] word);
      int bad = 0;
      for (int i = 0; i < stall; i++) begin
         done   = (i == 5);
         ack_ok = (i == 5);
         @(negedge clk);
         if (cmd_valid !== 1'b1 || cmd_word !== word) bad++;
      end
      done   = 1'b0;
      ack_ok = 1'b0;
      if (stall > 0) check_eq("stall_stable", bad, 0);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check_eq("cmd_valid_fall", cmd_valid, 0);
   endtask

   task automatic finish_cmd(input logic ack);
      repeat (3) @(negedge clk);
      done   = 1'b1;
      ack_ok = ack;
      @(negedge clk);
      done   = 1'b0;
      ack_ok = 1'b0;
   endtask

   task automatic serve(input logic ack, input int stall, input bit spurious, output int gap);
      logic [23:0] word;
      logic [23:0] exp;
      wait_cmd(spurious, word, gap);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      check_eq("cmd_word", {8'h00, word}, {8'h00, exp});
      accept_cmd(stall, word);
      finish_cmd(ack);
   endtask

   task automatic check_gap(input int idx, input int gap);
      if (idx == 0) check_eq("first_latency", gap, 0);
      else check_eq("done_to_valid", gap, GAP + 1);
   endtask

   initial begin
      int gap;
      int n;
      int n_nack;
      int seq_idx[$];
      logic seq_ack[$];

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_cmd_valid", cmd_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_init_done", init_done, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_cmd_word", cmd_word, 0);
      check_eq("rst_state", dbg_state, 0);

      // Full boot with a 20-cycle stall on index 1 and spurious done pulses
      for (int i = 0; i < 9; i++) exp_q.push_back(boot_words[i]);
      pulse_start();
      check_eq("boot_busy", busy, 1);
      for (int i = 0; i < 9; i++) begin
         serve(1'b1, (i == 1) ? 20 : 0, (i == 2), gap);
         check_gap(i, gap);
      end
      repeat (GAP) @(negedge clk);
      check_eq("init_done_early", init_done, 0);
      @(negedge clk);
      check_eq("boot_init_done", init_done, 1);
      check_eq("boot_error", error, 0);
      check_eq("boot_busy_end", busy, 0);
      check_eq("boot_req_ready", req_ready, 1);

      // start and req_valid together in READY: boot restarts, request held until READY
      req_valid = 1'b1;
      req_addr  = 7'd2;
      req_data  = 9'h07F;
      start     = 1'b1;
      #1;
      check_eq("req_ready_start_wins", req_ready, 0);
      @(negedge clk);
      start = 1'b0;
      check_eq("restart_init_clr", init_done, 0);
      for (int i = 0; i < 9; i++) exp_q.push_back(boot_words[i]);
      for (int i = 0; i < 9; i++) begin
         serve(1'b1, 0, 1'b0, gap);
         check_gap(i, gap);
         if (i == 4) check_eq("req_ready_boot", req_ready, 0);
      end
      n = 0;
      while (req_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("req_wait_cycles", n, GAP + 1);
      check_eq("req_after_init", init_done, 1);
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("req_cmd_valid", cmd_valid, 1);
      exp_q.push_back(24'h34047F);
      serve(1'b1, 0, 1'b0, gap);
      check_eq("req_latency", gap, 0);
      repeat (GAP + 1) @(negedge clk);
      check_eq("req_back_ready", req_ready, 1);

      // NACK index 3 twice, then ACK
      seq_idx.delete();
      seq_ack.delete();
      for (int i = 0; i < 4; i++) begin
         seq_idx.push_back(i);
         seq_ack.push_back(i != 3);
      end
`ifdef CODEC_CFG_RETRY_EN
      seq_idx.push_back(3); seq_ack.push_back(1'b0);
      seq_idx.push_back(3); seq_ack.push_back(1'b1);
      for (int i = 4; i < 9; i++) begin
         seq_idx.push_back(i);
         seq_ack.push_back(1'b1);
      end
`endif
      foreach (seq_idx[k]) exp_q.push_back(boot_words[seq_idx[k]]);
      pulse_start();
      foreach (seq_idx[k]) begin
         serve(seq_ack[k], 0, 1'b0, gap);
         check_gap(k, gap);
      end
`ifdef CODEC_CFG_RETRY_EN
      repeat (GAP + 1) @(negedge clk);
      check_eq("nack_init_done", init_done, 1);
      check_eq("nack_error", error, 0);
`else
      check_eq("nack_error", error, 1);
      check_eq("nack_init_done", init_done, 0);
      check_eq("nack_busy", busy, 0);
`endif

      // Every command NACKed: retries exhaust on the first word
`ifdef CODEC_CFG_RETRY_EN
      n_nack = 4;
`else
      n_nack = 1;
`endif
      for (int i = 0; i < n_nack; i++) exp_q.push_back(24'h341E00);
      pulse_start();
      check_eq("exh_error_clr", error, 0);
      for (int i = 0; i < n_nack; i++) begin
         serve(1'b0, 0, 1'b0, gap);
         check_gap(i, gap);
      end
      check_eq("exh_error", error, 1);
      check_eq("exh_busy", busy, 0);
      check_eq("exh_init_done", init_done, 0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) n++;
      end
      check_eq("exh_no_cmd", n, 0);

      // Reset during WAIT of index 4
      for (int i = 0; i < 4; i++) exp_q.push_back(boot_words[i]);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         serve(1'b1, 0, 1'b0, gap);
         check_gap(i, gap);
      end
      begin
         logic [23:0] word;
         wait_cmd(1'b0, word, gap);
         check_eq("idx4_word", word, 24'h340E52);
         accept_cmd(0, word);
      end
      check_eq("idx4_wait_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_cmd_valid", cmd_valid, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_init_done", init_done, 0);
      check_eq("mid_rst_error", error, 0);
      check_eq("mid_rst_req_ready", req_ready, 0);
      check_eq("mid_rst_cmd_word", cmd_word, 0);
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) n++;
      end
      check_eq("post_rst_quiet", n, 0);
      pulse_start();
      check_eq("restart_valid", cmd_valid, 1);
      check_eq("restart_word", cmd_word, 24'h341E00);

      check_eq("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Sequences WM8731 codec configuration over the shared I2C byte-level master. On `start` it walks a fixed boot table of nine register writes and issues each one to the master as a 24-bit command. It retries a command that is NACKed, and spaces commands by a programmable idle gap. After boot it arbitrates single runtime register writes (volume, mute, path changes) from the audio control logic onto the same master. It sits between the top-level control FSM and the I2C master that drives `i2c_clk`/`i2c_dat`.

## Interface
- `DEV_ADDR`, 8'h34: codec write address byte (7-bit address plus W bit).
- `GAP_CYCLES`, 64: idle `clk` cycles between a `done` and the next `cmd_valid`; ≥1.
- `MAX_RETRY`, 3: extra attempts per command after a NACK.
- `clk` input 1: single clock; all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse; begins (or restarts) the boot sequence.
- `req_valid` input 1: runtime write request.
- `req_addr` input 7: runtime register address.
- `req_data` input 9: runtime register data.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `cmd_valid` output 1: command to the I2C master is valid.
- `cmd_word` output 24: {DEV_ADDR, reg_addr[6:0], data[8:0]}.
- `cmd_ready` input 1: master accepts the command.
- `done` input 1: one-cycle pulse; the master has finished the transfer.
- `ack_ok` input 1: qualified by `done`; 1 means all three bytes were ACKed.
- `busy` output 1: a command is outstanding or the boot sequence is running.
- `init_done` output 1: boot table completed successfully; sticky until `reset` or `start`.
- `error` output 1: a command exhausted its retries; sticky until `reset` or `start`.

## Operation
- Boot table, in index order as {addr, data}:
  - 0: R15 = 0x000 (reset)
  - 1: R4 = 0x014
  - 2: R2 = 0x079
  - 3: R3 = 0x079
  - 4: R7 = 0x052
  - 5: R8 = 0x000
  - 6: R5 = 0x011
  - 7: R6 = 0x000
  - 8: R9 = 0x001 (active; always last)
- States:
  - IDLE: go to ISSUE when `start`, with idx=0 and retry=0.
  - ISSUE: hold `cmd_valid`; go to WAIT on `cmd_ready`.
  - WAIT: wait for `done`.
    - `ack_ok` and boot: idx+1, go to GAP. After idx 8, go to GAP and then READY instead.
    - `ack_ok` and runtime: go to GAP, then READY.
    - NACK with retry<MAX_RETRY: retry+1, go to GAP, then ISSUE the same word.
    - NACK with retry=MAX_RETRY: go to ERR.
  - GAP: count GAP_CYCLES, then go to the next state. `retry` clears whenever a command is ACKed.
  - READY: `init_done`=1 and `req_ready`=1. Accepting a request latches {req_addr, req_data} and goes to ISSUE.
  - ERR: `error`=1; stay until `start` or `reset`.
- `cmd_word` is registered and stable from `cmd_valid` rising until the `cmd_ready` handshake.
- `start` in any state other than IDLE, READY or ERR is ignored.
- `start` in READY or ERR clears `init_done`/`error` and restarts at idx 0.
- `start` and `req_valid` in the same READY cycle: `start` wins and `req_ready` is 0 that cycle.
- `req_ready` is 0 in every state except READY. A `req_valid` raised before `init_done` is not lost; it waits.
- `done` outside WAIT is ignored.
- `busy` is 1 in ISSUE, WAIT and GAP.

## Timing
- Reset values: `cmd_valid`, `busy`, `init_done`, `error`, `req_ready` = 0; `cmd_word` = 0; state = IDLE.
- `reset` mid-transfer abandons the command without issuing any further `cmd_valid`. Resetting the master is the top level's responsibility.
- `start` at cycle N drives `cmd_valid`=1 at N+1, carrying word 0 = 24'h341E00.
- `cmd_valid` falls the cycle after `cmd_ready` is sampled high.
- After `done`, the next `cmd_valid` rises exactly GAP_CYCLES+1 cycles later.
- A runtime request accepted at cycle N drives `cmd_valid` at N+1.
- `init_done` rises on the cycle GAP exits after the idx 8 ACK.
- The GAP counter and idx counter never wrap; idx stops at 8.

## Configuration
- `CODEC_CFG_RETRY_EN` defined: NACK retry behaviour as described, up to MAX_RETRY.
- `CODEC_CFG_RETRY_EN` undefined: the retry counter is removed, and any NACK goes directly from WAIT to ERR. MAX_RETRY is ignored.

## Test plan
- Boot sequence: `start`, with the master model ACKing all commands.
  - Nine `cmd_word` values appear in table order: 341E00, 340814, 340479, 340679, 340E52, 341000, 340A11, 340C00, 341201.
  - Spacing between `done` and the next `cmd_valid` is 65 cycles.
  - `init_done`=1 and `error`=0 at the end.
- NACK with retry: NACK index 3 twice, then ACK.
  - With `CODEC_CFG_RETRY_EN`: 340679 is issued three times and boot completes.
  - Without the macro: `error`=1 after the first NACK and `init_done`=0.
- Retry exhaustion: NACK every command, with the macro defined.
  - 341E00 is issued 4 times, then `error`=1, `busy`=0, and no further `cmd_valid`.
- Runtime arbitration: hold `req_valid` with R2=0x07F from before `start`.
  - Accepted only after `init_done`, in READY; `cmd_word`=34047F.
  - Simultaneous `start`+`req_valid` in READY: the boot restarts and the request is deferred.
- Handshake stall: hold `cmd_ready`=0 for 20 cycles.
  - `cmd_valid` and `cmd_word` stay stable throughout.
  - A spurious `done` during ISSUE or GAP has no effect.
- Reset mid-operation: assert `reset` during WAIT of index 4.
  - All outputs 0 on the next cycle.
  - A subsequent `start` restarts at 341E00.
